// File: rtl/sw_pkg.sv
// sw_pkg: base encodings, FSM states and score saturation shared by the SW/NW array
package sw_pkg;
  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_T = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_C = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FIN} state_t;
  function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    return x > hi ? hi : x < -hi - 32'sd1 ? -hi - 32'sd1 : x;
  endfunction
endpackage

// File: rtl/sw_pe.sv
// sw_pe: one wavefront cell owning row I of the score matrix, fed by the row above
module sw_pe
  import sw_pkg::*;
#(
  parameter int N_BASES = 12,
  parameter int SCORE_W = 8,
  parameter int KW = 5,
  parameter int I = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_load,
  input  logic                      i_run,
  input  logic                      i_mode,
  input  logic [KW-1:0]             i_k,
  input  logic [1:0]                i_r,
  input  logic [1:0]                i_q,
  input  logic [SCORE_W-1:0]        i_match,
  input  logic [SCORE_W-1:0]        i_mism,
  input  logic [SCORE_W-1:0]        i_gap,
  input  logic signed [SCORE_W-1:0] i_up,
  output logic signed [SCORE_W-1:0] o_h,
  output logic signed [SCORE_W-1:0] o_hc,
  output logic                      o_vld
);
  localparam int XW = SCORE_W + 2;
  logic [1:0] r_rb;
  logic signed [SCORE_W-1:0] r_h;
  logic signed [SCORE_W-1:0] r_diag;
  logic signed [SCORE_W-1:0] w_left0;
  logic signed [SCORE_W-1:0] w_diag0;
  logic signed [XW-1:0] w_s;
  logic signed [XW-1:0] w_d;
  logic signed [XW-1:0] w_u;
  logic signed [XW-1:0] w_l;
  logic signed [XW-1:0] w_du;
  logic signed [XW-1:0] w_m0;
  logic signed [XW-1:0] w_m;
  assign o_vld = i_run && int'(i_k) >= I && int'(i_k) < I + N_BASES;
  assign w_s = r_rb == i_q ? $signed(XW'(i_match)) : -$signed(XW'(i_mism));
  assign w_d = XW'(r_diag) + w_s;
  assign w_u = XW'(i_up) - $signed(XW'(i_gap));
  assign w_l = XW'(r_h) - $signed(XW'(i_gap));
  assign w_du = w_d > w_u ? w_d : w_u;
  assign w_m0 = w_du > w_l ? w_du : w_l;
  assign w_m = !i_mode && w_m0[XW-1] ? '0 : w_m0;
  assign o_hc = SCORE_W'(sat(32'(w_m), SCORE_W));
  assign o_h = r_h;
  // Global-mode column -1 boundary is preloaded so the first cell needs no special case
  assign w_left0 = i_mode ? SCORE_W'(sat(-(I + 1) * int'(i_gap), SCORE_W)) : '0;
  assign w_diag0 = i_mode ? SCORE_W'(sat(-I * int'(i_gap), SCORE_W)) : '0;
  always_ff @(posedge clk)
    if (reset) begin
      r_rb <= '0;
      r_h <= '0;
      r_diag <= '0;
    end else if (i_load) begin
      r_rb <= i_r;
      r_h <= w_left0;
      r_diag <= w_diag0;
    end else if (o_vld) begin
      r_h <= o_hc;
      r_diag <= i_up;
    end
endmodule

// File: rtl/sw_score_array.sv
// sw_score_array: linear systolic Smith-Waterman / Needleman-Wunsch scorer with best-cell tracking
module sw_score_array
  import sw_pkg::*;
#(
  parameter int N_BASES = 12,
  parameter int SCORE_W = 8,
  parameter int IDX_W = $clog2(N_BASES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      mode,
  input  logic [2*N_BASES-1:0]      R,
  input  logic [2*N_BASES-1:0]      Q,
  input  logic [SCORE_W-1:0]        match_sc,
  input  logic [SCORE_W-1:0]        mismatch_pen,
  input  logic [SCORE_W-1:0]        gap_pen,
  output logic                      busy,
  output logic                      done,
  output logic signed [SCORE_W-1:0] score,
  output logic [IDX_W-1:0]          r_end,
  output logic [IDX_W-1:0]          q_end
);
  localparam int KW = $clog2(2 * N_BASES);
  state_t r_state;
  logic [KW-1:0] r_k;
  logic r_mode;
  logic [SCORE_W-1:0] r_match;
  logic [SCORE_W-1:0] r_mism;
  logic [SCORE_W-1:0] r_gap;
  logic [2*N_BASES-1:0] r_qs;
  logic [1:0] r_qd [N_BASES-1];
  logic signed [SCORE_W-1:0] r_top;
  logic w_load;
  logic w_run;
  logic w_mode;
  logic [SCORE_W-1:0] w_gap;
  logic [1:0] w_q [N_BASES];
  logic signed [SCORE_W-1:0] w_up [N_BASES];
  logic signed [SCORE_W-1:0] w_h [N_BASES];
  logic signed [SCORE_W-1:0] w_hc [N_BASES];
  logic w_vld [N_BASES];
  logic signed [SCORE_W-1:0] w_bv;
  logic [IDX_W-1:0] w_br;
  logic [IDX_W-1:0] w_bq;
  assign w_load = r_state == S_LOAD;
  assign w_run = r_state == S_RUN;
  // PEs preload their boundaries during LOAD, before the latched copies are valid
  assign w_mode = w_load ? mode : r_mode;
  assign w_gap = w_load ? gap_pen : r_gap;
  for (genvar i = 0; i < N_BASES; i++) begin : g_pe
    if (i == 0) begin : g_first
      assign w_q[i] = r_qs[1:0];
      assign w_up[i] = r_top;
    end else begin : g_rest
      assign w_q[i] = r_qd[i-1];
      assign w_up[i] = w_h[i-1];
    end
    sw_pe #(
      .N_BASES(N_BASES),
      .SCORE_W(SCORE_W),
      .KW(KW),
      .I(i)
    ) u_pe (
      .clk(clk),
      .reset(reset),
      .i_load(w_load),
      .i_run(w_run),
      .i_mode(w_mode),
      .i_k(r_k),
      .i_r(R[2*i +: 2]),
      .i_q(w_q[i]),
      .i_match(r_match),
      .i_mism(r_mism),
      .i_gap(w_gap),
      .i_up(w_up[i]),
      .o_h(w_h[i]),
      .o_hc(w_hc[i]),
      .o_vld(w_vld[i])
    );
  end
  always_ff @(posedge clk)
    for (int n = 0; n < N_BASES - 1; n++)
      r_qd[n] <= reset ? 2'b0 : w_run ? w_q[n] : r_qd[n];
  // Ascending scan with strict > keeps the lowest row on a tie and never displaces an earlier diagonal
  always_comb begin
    w_bv = score;
    w_br = r_end;
    w_bq = q_end;
    for (int n = 0; n < N_BASES; n++)
      if (w_vld[n] && w_hc[n] > w_bv) begin
        w_bv = w_hc[n];
        w_br = IDX_W'(n);
        w_bq = IDX_W'(int'(r_k) - n);
      end
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= S_IDLE;
      r_k <= '0;
      r_mode <= 1'b0;
      r_match <= '0;
      r_mism <= '0;
      r_gap <= '0;
      r_qs <= '0;
      r_top <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      score <= '0;
      r_end <= '0;
      q_end <= '0;
    end else begin
      busy <= r_state == S_LOAD || r_state == S_RUN;
      done <= r_state == S_FIN;
      case (r_state)
        S_IDLE: r_state <= start ? S_LOAD : S_IDLE;
        S_LOAD: begin
          r_state <= S_RUN;
          r_k <= '0;
          r_mode <= mode;
          r_match <= match_sc;
          r_mism <= mismatch_pen;
          r_gap <= gap_pen;
          r_qs <= Q;
          r_top <= mode ? SCORE_W'(sat(-int'(gap_pen), SCORE_W)) : '0;
          score <= '0;
          r_end <= '0;
          q_end <= '0;
        end
        S_RUN: begin
          r_k <= r_k + 1'b1;
          r_qs <= r_qs >> 2;
          r_top <= r_mode ? SCORE_W'(sat(32'(r_top) - int'(r_gap), SCORE_W)) : '0;
          if (!r_mode) begin
            score <= w_bv;
            r_end <= w_br;
            q_end <= w_bq;
          end
          if (r_k == KW'(2 * N_BASES - 2)) r_state <= S_FIN;
        end
        default: begin
          r_state <= S_IDLE;
          if (r_mode) begin
            score <= w_h[N_BASES-1];
            r_end <= IDX_W'(N_BASES - 1);
            q_end <= IDX_W'(N_BASES - 1);
          end
        end
      endcase
    end
endmodule

// File: tb/tb_sw_score_array.sv
// tb_sw_score_array: directed checks of scoring modes, latency, saturation, reset abort and handshake
module tb_sw_score_array;
  localparam logic [23:0] ID = 24'h6d10c8;
  localparam logic [23:0] SUB = 24'h6d10c9;
  localparam logic [23:0] ALL_T = 24'h555555;
  logic clk = 1'b0;
  logic reset;
  logic start;
  logic mode;
  logic [23:0] R;
  logic [23:0] Q;
  logic [7:0] match_sc = 8'd2;
  logic [7:0] mism_pen = 8'd1;
  logic [7:0] gap_pen = 8'd1;
  logic [4:0] match5 = 5'd2;
  logic [4:0] mism5 = 5'd1;
  logic [4:0] gap5 = 5'd1;
  logic busy;
  logic done;
  logic signed [7:0] score;
  logic [3:0] r_end;
  logic [3:0] q_end;
  logic busy5;
  logic done5;
  logic signed [4:0] score5;
  logic [3:0] r_end5;
  logic [3:0] q_end5;
  int n_tests = 0;
  int n_fail = 0;
  int lat;
  int n_done;
  int s_first;
  int e_first;
  int s_second;
  always #5 clk = ~clk;
  sw_score_array #(.N_BASES(12), .SCORE_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .R(R), .Q(Q),
    .match_sc(match_sc), .mismatch_pen(mism_pen), .gap_pen(gap_pen),
    .busy(busy), .done(done), .score(score), .r_end(r_end), .q_end(q_end)
  );
  sw_score_array #(.N_BASES(12), .SCORE_W(5)) u_sat (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .R(R), .Q(Q),
    .match_sc(match5), .mismatch_pen(mism5), .gap_pen(gap5),
    .busy(busy5), .done(done5), .score(score5), .r_end(r_end5), .q_end(q_end5)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask
  task automatic run(input logic m, input logic [23:0] r, input logic [23:0] q, output int l);
    @(negedge clk);
    mode = m;
    R = r;
    Q = q;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    l = -1;
    for (int c = 1; c <= 100 && l < 0; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) l = c;
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    R = '0;
    Q = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_r_end", 32'(r_end), 0);
    chk("rst_q_end", 32'(q_end), 0);
    reset = 1'b0;
    run(1'b0, ID, ID, lat);
    chk("id_loc_latency", lat, 25);
    chk("id_loc_score", 32'(score), 24);
    chk("id_loc_r_end", 32'(r_end), 11);
    chk("id_loc_q_end", 32'(q_end), 11);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("score_holds", 32'(score), 24);
    run(1'b0, ID, SUB, lat);
    chk("sub_loc_score", 32'(score), 22);
    chk("sub_loc_r_end", 32'(r_end), 11);
    chk("sub_loc_q_end", 32'(q_end), 11);
    run(1'b1, ID, SUB, lat);
    chk("sub_glb_latency", lat, 25);
    chk("sub_glb_score", 32'(score), 21);
    chk("sub_glb_r_end", 32'(r_end), 11);
    chk("sub_glb_q_end", 32'(q_end), 11);
    run(1'b0, 24'h000000, ALL_T, lat);
    chk("mis_loc_score", 32'(score), 0);
    chk("mis_loc_r_end", 32'(r_end), 0);
    chk("mis_loc_q_end", 32'(q_end), 0);
    run(1'b1, 24'h000000, ALL_T, lat);
    chk("mis_glb_score", 32'(score), -12);
    chk("mis_glb_r_end", 32'(r_end), 11);
    run(1'b1, ID, ID, lat);
    chk("sat_w8_score", 32'(score), 24);
    chk("sat_w5_score", 32'(score5), 15);
    chk("sat_w5_r_end", 32'(r_end5), 11);
    @(negedge clk);
    mode = 1'b0;
    R = ID;
    Q = ID;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 1);
    chk("abort_partial_score", 32'(score), 6);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy_after", 32'(busy), 0);
    chk("abort_score", 32'(score), 0);
    chk("abort_r_end", 32'(r_end), 0);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    run(1'b0, ID, ID, lat);
    chk("post_abort_latency", lat, 25);
    chk("post_abort_score", 32'(score), 24);
    @(negedge clk);
    mode = 1'b0;
    R = ID;
    Q = ID;
    start = 1'b1;
    @(posedge clk);
    n_done = 0;
    s_first = -99;
    e_first = -99;
    s_second = -99;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c == 3) begin
        R = 24'h000000;
        Q = ALL_T;
      end
      if (c == 40) start = 1'b0;
      if (done) begin
        n_done++;
        if (n_done == 1) begin
          s_first = int'(score);
          e_first = int'(r_end);
        end else s_second = int'(score);
      end
    end
    chk("hs_done_count", n_done, 2);
    chk("hs_first_score", s_first, 24);
    chk("hs_first_r_end", e_first, 11);
    chk("hs_second_score", s_second, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sw_score_array.md
Name: sw_score_array

Overview:
- Parametrised successor to the fixed 12-base bsw_acc front-end: a linear systolic array of N_BASES processing elements (PEs) that scores one reference/query pair.
- Supports Smith-Waterman (local) and Needleman-Wunsch (global) modes, with runtime-programmable match/mismatch/gap values.
- Returns the best score and its end coordinates, using a start/busy/done handshake.
- Sits ahead of a traceback unit: the end coordinates seed the traceback.

Parameters:
N_BASES, 12, sequence length in bases for both R and Q (2..64).
SCORE_W, 8, signed score width in bits (4..16).
IDX_W, $clog2(N_BASES), width of the end-coordinate outputs.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request to begin alignment; sampled only in IDLE
mode  in  1  0 = local (SW), 1 = global (NW); latched at start
R  in  2*N_BASES  reference; base i = R[2i+1:2i]; encoding A=0, T=1, G=2, C=3
Q  in  2*N_BASES  query; same packing as R
match_sc  in  SCORE_W  unsigned match reward
mismatch_pen  in  SCORE_W  unsigned mismatch penalty (subtracted)
gap_pen  in  SCORE_W  unsigned linear gap penalty (subtracted)
busy  out  1  high in LOAD and RUN
done  out  1  one-cycle pulse in FIN; results valid from this cycle
score  out  SCORE_W  signed best score
r_end  out  IDX_W  reference index of the best cell
q_end  out  IDX_W  query index of the best cell

Behaviour:
- Reset: all outputs are zero; FSM returns to IDLE. Reset mid-RUN aborts the run: no done pulse, results cleared.
- FSM states: IDLE, LOAD, RUN, FIN.
  - IDLE -> LOAD when start=1.
  - LOAD (1 cycle): latches R, Q, mode and the three scoring values; clears the wavefront and the running maximum (max=0, ends=0,0). Runs the same way in both modes.
  - RUN lasts 2*N_BASES-1 cycles, counted by the diagonal counter k.
  - FIN (1 cycle): done=1, then -> IDLE.
- Latency: start sampled at edge t0 -> done high in the cycle starting at edge t0+2*N_BASES+1.
- start in any state other than IDLE is ignored. Inputs may change after LOAD without effect.
- score/r_end/q_end hold their values after FIN until the next LOAD clears them.
- Wavefront: in RUN cycle k, PE i computes cell (i, j=k-i) when 0<=j<N_BASES; otherwise the PE holds its state.
  - Cell value: H(i,j) = max(diag + s, up - gap_pen, left - gap_pen), where s = +match_sc if R_i==Q_j, else -mismatch_pen.
  - Local mode adds a floor of 0 to that max.
- Boundaries:
  - Local: H(-1,*) = H(*,-1) = 0.
  - Global: H(-1,j) = -(j+1)*gap_pen, H(i,-1) = -(i+1)*gap_pen, H(-1,-1) = 0.
- Arithmetic:
  - Intermediates use SCORE_W+2 bits, then saturate to the signed SCORE_W range.
  - Every stored H value is saturated.
- Result, local mode: max over all cells. A replacement happens only on strictly greater. Within one diagonal the lowest i wins; an earlier diagonal beats a later one. If no cell exceeds 0, the result is score 0 at ends (0,0).
- Result, global mode: score = H(N-1,N-1); r_end = q_end = N-1.

Decomposition:
- Package sw_pkg: base encoding constants (A/T/G/C), FSM state enum, and a saturation function sat(x, SCORE_W).
- Sub-module sw_pe: one cell. It holds its latched R base and its diag/up registers and produces H plus a valid flag.
- Top level: generate-loop of N_BASES sw_pe instances, Q shift chain, FSM, diagonal counter, and max-tracking reduction.

Test Plan:
- Identical match, local: N=12, SCORE_W=8, R=Q=24'h6d10c8, mode=0, match=2, mism=1, gap=1 -> done at t0+25, score=24, r_end=11, q_end=11.
- Single substitution: R=24'h6d10c8, Q=24'h6d10c9 (base 0 differs), same scoring.
  - mode=0 -> score=22, ends (11,11).
  - mode=1 -> score=21, ends (11,11).
- All-mismatch: R=24'h000000, Q=24'h555555, same scoring.
  - mode=0 -> score=0, ends (0,0).
  - mode=1 -> score=-12 (0xF4).
- Saturation: SCORE_W=5, R=Q=24'h6d10c8, match=2, mode=1 -> score=15, no wrap to negative.
- Reset mid-run: reset=1 for one cycle at RUN cycle k=5 -> busy=0 next cycle, no done pulse, score=0. A following start with identical sequences -> score=24 at the normal latency.
- Handshake: hold start high for 40 cycles -> exactly one done pulse per accepted start; start during busy is ignored. Change R/Q during RUN -> result unchanged.
